// File: rtl/alineador_receptor.sv
// Receiver aligner: finds K28.5 commas in a serial 8b/10b stream, locks the
// symbol phase and emits one aligned 10-bit symbol per boundary.
module alineador_receptor #(
    parameter int VERIF_MAX = 4,
    parameter int ERR_MAX   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       serialIn,
    output logic [9:0] dataOut,
    output logic       validOut,
    output logic       comaDet,
    output logic       alineado
);

    localparam int VW = $clog2(VERIF_MAX + 1);
    localparam int EW = $clog2(ERR_MAX + 1);
    localparam logic [VW-1:0] VLAST = VW'(VERIF_MAX - 1);
    localparam logic [EW-1:0] ELAST = EW'(ERR_MAX - 1);

    typedef enum logic [1:0] {
        BUSCAR    = 2'd0,
        VERIFICAR = 2'd1,
        ALINEADO  = 2'd2
    } state_t;

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == 10'b0011111010) || (sym == 10'b1100000101);
    endfunction

    logic [9:0]    sr_r;
    logic [3:0]    fase_r;
    logic [VW-1:0] vcnt_r;
    logic [EW-1:0] err_r;
    state_t        state_r;

    logic          match_s;
    logic          bnd_s;
    logic          emit_s;
    logic          capture_s;
    logic [3:0]    fase_s;
    logic [VW-1:0] vcnt_s;
    logic [EW-1:0] err_s;
    state_t        state_s;

    assign match_s = is_comma(sr_r);
    assign bnd_s   = (fase_r >= 4'd9);

    // Next-state, counter and emit decisions for the current enabled edge.
    always_comb begin
        state_s   = state_r;
        vcnt_s    = vcnt_r;
        err_s     = err_r;
        emit_s    = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            BUSCAR: begin
                if (match_s) begin
                    capture_s = 1'b1;
                    state_s   = VERIFICAR;
                    vcnt_s    = '0;
                end else begin
                    state_s   = BUSCAR;
                end
            end
            VERIFICAR: begin
                if (bnd_s) begin
                    emit_s = 1'b1;
                    if (match_s) begin
                        state_s = ALINEADO;
                        err_s   = '0;
                        vcnt_s  = '0;
                    end else if (vcnt_r == VLAST) begin
                        state_s = BUSCAR;
                        vcnt_s  = '0;
                    end else begin
                        vcnt_s  = vcnt_r + VW'(1);
                    end
                end else if (match_s) begin
                    // Comma off the tentative phase: restart verification there.
                    capture_s = 1'b1;
                    vcnt_s    = '0;
                end else begin
                    vcnt_s    = vcnt_r;
                end
            end
            ALINEADO: begin
                if (bnd_s) begin
                    emit_s = 1'b1;
                    if (match_s) begin
                        err_s = '0;
                    end else begin
                        err_s = err_r;
                    end
                end else if (match_s) begin
                    if (err_r == ELAST) begin
                        capture_s = 1'b1;
                        state_s   = VERIFICAR;
                        err_s     = '0;
                        vcnt_s    = '0;
                    end else begin
                        err_s     = err_r + EW'(1);
                    end
                end else begin
                    err_s = err_r;
                end
            end
            default: begin
                state_s = BUSCAR;
                vcnt_s  = '0;
                err_s   = '0;
            end
        endcase

        if (capture_s || bnd_s) begin
            fase_s = 4'd0;
        end else begin
            fase_s = fase_r + 4'd1;
        end
    end

    // State, phase counter, shift register and error/verification counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_r    <= 10'd0;
            fase_r  <= 4'd0;
            vcnt_r  <= '0;
            err_r   <= '0;
            state_r <= BUSCAR;
        end else if (enb) begin
            sr_r    <= {sr_r[8:0], serialIn};
            fase_r  <= fase_s;
            vcnt_r  <= vcnt_s;
            err_r   <= err_s;
            state_r <= state_s;
        end else begin
            sr_r    <= sr_r;
            fase_r  <= fase_r;
            vcnt_r  <= vcnt_r;
            err_r   <= err_r;
            state_r <= state_r;
        end
    end

    // Registered outputs; dataOut holds between pulses, flags pulse for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataOut  <= 10'd0;
            validOut <= 1'b0;
            comaDet  <= 1'b0;
            alineado <= 1'b0;
        end else begin
            validOut <= 1'b0;
            comaDet  <= 1'b0;
            if (enb) begin
                alineado <= (state_s == ALINEADO);
                if (emit_s || capture_s) begin
                    dataOut  <= sr_r;
                    validOut <= 1'b1;
                    comaDet  <= match_s;
                end else begin
                    dataOut  <= dataOut;
                end
            end else begin
                alineado <= alineado;
                dataOut  <= dataOut;
            end
        end
    end

endmodule

// File: tb/tb_alineador_receptor.sv
// Self-checking bench for alineador_receptor: table of stream steps, expected
// pulses queued as stimulus is driven and compared when validOut fires.
module tb_alineador_receptor;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       serialIn;
    logic [9:0] dataOut;
    logic       validOut;
    logic       comaDet;
    logic       alineado;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alineador_receptor #(.VERIF_MAX(4), .ERR_MAX(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .serialIn (serialIn),
        .dataOut  (dataOut),
        .validOut (validOut),
        .comaDet  (comaDet),
        .alineado (alineado)
    );

    localparam logic [9:0] KN = 10'b0011111010;
    localparam logic [9:0] KP = 10'b1100000101;
    localparam logic [9:0] D1 = 10'b1001110100;
    localparam logic [9:0] D2 = 10'b0111010100;
    localparam logic [9:0] D3 = 10'b1011010100;

    typedef enum int {OP_RST, OP_BITS, OP_GAP, OP_END, OP_ARST} op_t;
    typedef struct {
        op_t        op;
        int         nb;
        logic [9:0] bits;
        int         ne;
        logic [11:0] e0;
        logic [11:0] e1;
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] exq[$];
    logic [11:0] mon_e;

    function automatic logic [11:0] ex(input logic [9:0] d, input logic c, input logic a);
        return {d, c, a};
    endfunction

    function automatic void add(input op_t op, input int nb, input logic [9:0] b,
                                input int ne, input logic [11:0] e0, input logic [11:0] e1);
        vec_t v;
        v.op = op; v.nb = nb; v.bits = b; v.ne = ne; v.e0 = e0; v.e1 = e1;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        enb      = 1'b1;
        serialIn = b;
        @(posedge clk);
        #1;
    endtask

    // Pulse monitor: every validOut must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (validOut === 1'b1) begin
                if (exq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got dataOut=%b comaDet=%b alineado=%b, expected no pulse (t=%0t)",
                             dataOut, comaDet, alineado, $time);
                end else begin
                    mon_e = exq.pop_front();
                    chk("pulse{data,coma,alineado}", {4'd0, dataOut, comaDet, alineado}, {4'd0, mon_e});
                end
            end else if (comaDet !== 1'b0) begin
                chk("comaDet_without_valid", {15'd0, comaDet}, 16'd0);
            end
        end
    end

    initial begin
        rst      = 1'b0;
        enb      = 1'b0;
        serialIn = 1'b0;

        // Acquisition with junk prefix, data, enable gap, lock.
        add(OP_RST,  0, 10'd0, 0, 12'd0, 12'd0);
        add(OP_BITS, 3, 10'b010, 0, 12'd0, 12'd0);
        add(OP_BITS, 10, KN, 1, ex(KN, 1'b1, 1'b0), 12'd0);
        add(OP_BITS, 10, D1, 1, ex(D1, 1'b0, 1'b0), 12'd0);
        add(OP_BITS, 5, 10'b01110, 0, 12'd0, 12'd0);
        add(OP_GAP,  5, 10'd0, 0, 12'd0, 12'd0);
        add(OP_BITS, 5, 10'b10100, 1, ex(D2, 1'b0, 1'b0), 12'd0);
        add(OP_BITS, 10, D3, 1, ex(D3, 1'b0, 1'b0), 12'd0);
        add(OP_BITS, 10, KP, 1, ex(KP, 1'b1, 1'b1), 12'd0);
        add(OP_BITS, 10, D1, 1, ex(D1, 1'b0, 1'b1), 12'd0);
        add(OP_BITS, 10, KN, 1, ex(KN, 1'b1, 1'b1), 12'd0);
        // One slipped bit: stale-phase pulses, tolerated error, then recapture.
        add(OP_BITS, 1, 10'd0, 0, 12'd0, 12'd0);
        add(OP_BITS, 10, D1, 1, ex(10'b0100111010, 1'b0, 1'b1), 12'd0);
        add(OP_BITS, 10, KN, 1, ex(10'b0001111101, 1'b0, 1'b1), 12'd0);
        add(OP_BITS, 10, D2, 1, ex(10'b0011101010, 1'b0, 1'b1), 12'd0);
        add(OP_BITS, 10, KP, 2, ex(10'b0110000010, 1'b0, 1'b1), ex(KP, 1'b1, 1'b0));
        add(OP_BITS, 10, D3, 1, ex(D3, 1'b0, 1'b0), 12'd0);
        add(OP_BITS, 10, KN, 1, ex(KN, 1'b1, 1'b1), 12'd0);
        add(OP_END,  0, 10'd0, 0, 12'd1, 12'd0);
        // Asynchronous reset mid-symbol while locked, then re-acquire.
        add(OP_BITS, 4, 10'b1001, 0, 12'd0, 12'd0);
        add(OP_ARST, 0, 10'd0, 0, 12'd0, 12'd0);
        add(OP_BITS, 10, KN, 1, ex(KN, 1'b1, 1'b0), 12'd0);
        add(OP_BITS, 10, KP, 1, ex(KP, 1'b1, 1'b1), 12'd0);
        add(OP_END,  0, 10'd0, 0, 12'd1, 12'd0);
        // Verification timeout: four pulses, then back to searching.
        add(OP_RST,  0, 10'd0, 0, 12'd0, 12'd0);
        add(OP_BITS, 10, KN, 1, ex(KN, 1'b1, 1'b0), 12'd0);
        add(OP_BITS, 10, D1, 1, ex(D1, 1'b0, 1'b0), 12'd0);
        add(OP_BITS, 10, D2, 1, ex(D2, 1'b0, 1'b0), 12'd0);
        add(OP_BITS, 10, D3, 1, ex(D3, 1'b0, 1'b0), 12'd0);
        add(OP_BITS, 10, D1, 1, ex(D1, 1'b0, 1'b0), 12'd0);
        add(OP_BITS, 10, D2, 0, 12'd0, 12'd0);
        add(OP_END,  0, 10'd0, 0, 12'd0, 12'd0);

        for (int k = 0; k < tbl.size(); k++) begin
            case (tbl[k].op)
                OP_RST: begin
                    rst = 1'b0;
                    enb = 1'b0;
                    exq.delete();
                    repeat (3) @(posedge clk);
                    #1;
                    chk("reset_outputs", {3'd0, dataOut, validOut, comaDet, alineado}, 16'd0);
                    rst = 1'b1;
                end
                OP_BITS: begin
                    if (tbl[k].ne > 0) exq.push_back(tbl[k].e0);
                    if (tbl[k].ne > 1) exq.push_back(tbl[k].e1);
                    for (int i = tbl[k].nb - 1; i >= 0; i--) send_bit(tbl[k].bits[i]);
                end
                OP_GAP: begin
                    enb      = 1'b0;
                    serialIn = 1'b1;
                    for (int i = 0; i < tbl[k].nb; i++) begin
                        @(posedge clk);
                        #1;
                        chk("gap_validOut", {15'd0, validOut}, 16'd0);
                    end
                end
                OP_END: begin
                    send_bit(1'b0);
                    send_bit(1'b0);
                    @(negedge clk);
                    #1;
                    chk("pending_pulses", 16'(exq.size()), 16'd0);
                    chk("alineado_end", {15'd0, alineado}, {15'd0, tbl[k].e0[0]});
                    exq.delete();
                end
                OP_ARST: begin
                    chk("alineado_before_arst", {15'd0, alineado}, 16'd1);
                    #2;
                    rst = 1'b0;
                    #1;
                    chk("async_reset_outputs", {3'd0, dataOut, validOut, comaDet, alineado}, 16'd0);
                    repeat (2) @(posedge clk);
                    #1;
                    chk("held_reset_outputs", {3'd0, dataOut, validOut, comaDet, alineado}, 16'd0);
                    rst = 1'b1;
                end
                default: begin
                    chk("bad_table_op", 16'd1, 16'd0);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
